// File: rtl/risc_pkg.sv
// Shared KGP-RISC definitions used by the execute-stage multiplier and control unit.
// The product-write codes steer the multiplier's high/low words into the dedicated product registers.
package risc_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

  localparam int ALU_CTRL_W = 5;
  localparam logic [ALU_CTRL_W-1:0] ALU_WR_PROD_HI = 5'b11000;
  localparam logic [ALU_CTRL_W-1:0] ALU_WR_PROD_LO = 5'b11001;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the control path and the sequential multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, prod_hi, prod_lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, prod_hi, prod_lo
  );

endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier on operand magnitudes with a final sign-fix step.
// Takes WIDTH+2 edges from accepted start to the done pulse.
module seq_multiplier
  import risc_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  seq_multiplier_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t state;
  mul_state_t state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic               sign;
  logic [WIDTH-1:0]   prod_hi_q;
  logic [WIDTH-1:0]   prod_lo_q;
  logic               done_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    case (state)
      CALC, FIX: bus.busy = 1'b1;
      default:   bus.busy = 1'b0;
    endcase
  end

  // The carry bit of the upper-half add becomes the MSB after the right shift.
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_neg = ~acc + (2*WIDTH)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      sign      <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.is_signed ? abs_val(bus.op_a) : bus.op_a;
            mplier <= bus.is_signed ? abs_val(bus.op_b) : bus.op_b;
            sign   <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        FIX: begin
          {prod_hi_q, prod_lo_q} <= sign ? acc_neg : acc;
          done_q                 <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done    = done_q;
  assign bus.prod_hi = prod_hi_q;
  assign bus.prod_lo = prod_lo_q;

endmodule
